tri_fetch: RTL and testbench
============================

// Module: tri_fetch
// PURPOSE
//  Triangle fetch stage directly upstream of the vertex shader. On start, walks a
//  contiguous triangle list in single-port vertex RAM (one 96-bit vertex per word,
//  three words per triangle). Assembles each triangle into homogeneous form (w = 1.0)
//  and hands it downstream over a valid/ready handshake. Pulses done after the last one.
// PARAMETERS
//  ADDR_WIDTH   16            vertex RAM address width; addresses wrap modulo 2^ADDR_WIDTH
//  RAM_LATENCY  2             cycles from mem_addr_out presented to mem_data_in valid (HIGH_PERF RAM)
//  W_ONE        32'h0001_0000 w component inserted per vertex (1.0 in Q16.16)
// PORTS
//  clk_in         in   1            system clock
//  rst_in         in   1            synchronous reset, active-low
//  start_in       in   1            begin fetch of a list; sampled only in IDLE
//  base_addr_in   in   ADDR_WIDTH   word address of vertex 0 of triangle 0; latched on start
//  num_tris_in    in   16           triangles in list; latched on start
//  mem_addr_out   out  ADDR_WIDTH   vertex RAM read address
//  mem_en_out     out  1            vertex RAM read enable; high only on issue cycles
//  mem_data_in    in   96           RAM read data {z[95:64], y[63:32], x[31:0]}
//  tri_out        out  384          {v2,v1,v0}; each vertex 128b {w,z,y,x}, v0 at [127:0]
//  tri_valid_out  out  1            tri_out holds a complete triangle
//  tri_ready_in   in   1            downstream accepts; transfer when valid & ready
//  busy_out       out  1            high in every state except IDLE
//  done_out       out  1            one-cycle pulse when the list is finished
// BEHAVIOUR
//  Reset (rst_in==0 at clk edge): state IDLE; mem_addr_out=0, mem_en_out=0, tri_out=0,
//   tri_valid_out=0, busy_out=0, done_out=0; issue/capture counters and tag pipe cleared.
//   Reset mid-list aborts immediately: in-flight RAM returns are discarded, no done pulse.
//  States: IDLE -> ISSUE -> WAIT -> HOLD -> (ISSUE | FINISH) ; FINISH -> IDLE.
//  IDLE: start_in=1 latches base/num, addr pointer=base. num==0 -> FINISH, else ISSUE.
//  ISSUE: 3 consecutive cycles, mem_en_out=1, mem_addr_out=ptr, ptr+=1 (wraps mod
//   2^ADDR_WIDTH). Each issue pushes a vertex-index tag (0,1,2) into a RAM_LATENCY-deep
//   shift pipe; tag emerging with data selects the v0/v1/v2 slot to capture mem_data_in.
//  WAIT: mem_en_out=0; leave when slot v2 captured. Capture inserts w=W_ONE in [127:96].
//  HOLD: tri_valid_out=1; tri_out stable while tri_ready_in=0 (no bubbles, no changes).
//   On handshake: tri_valid_out=0 next cycle; tri count+=1; count==num -> FINISH, else
//   ISSUE begins the very next cycle.
//  FINISH: done_out=1 for exactly this cycle, busy_out still 1; then IDLE.
//  Timing (RAM_LATENCY=L): start sampled cycle 0 -> issues cycles 1,2,3 -> tri_valid_out
//   high from cycle 4+L. With ready held high, one triangle per 4+L cycles.
//  start_in while busy_out=1: ignored. tri_ready_in while valid=0: ignored.
//  Base near top of address space: reads wrap to 0 without error; triangle continues.
//  Last-triangle handshake and FINISH: done_out asserts cycle after final handshake.
// TESTING
//  1 base=0x0010,num=1,L=2; RAM[0x10..0x12]=distinct x/y/z, ready=1 -> addrs 0x10,0x11,0x12
//    on cycles 1-3, valid at cycle 6, tri_out w fields=0x00010000, done pulse cycle 7.
//  2 num=4, ready=1 -> 12 sequential reads, 4 transfers spaced exactly 6 cycles, one done.
//  3 num=2, ready low 10 cycles after valid -> tri_out/valid stable all 10 cycles, no new
//    mem_en_out until handshake, then second triangle correct, single done pulse.
//  4 num=0 -> no mem_en_out, no valid, done_out high at cycle 1, busy_out high cycle 1 only.
//  5 base=0xFFFE,num=1 -> addresses 0xFFFE,0xFFFF,0x0000; v2 taken from RAM[0x0000].
//  6 num=3, rst_in low during second triangle WAIT -> all outputs 0 next edge, no done;
//    new start after reset fetches cleanly from its own base.

Source files
------------

// File: rtl/tri_fetch_if.sv
// Vertex RAM read port and triangle output handshake of the triangle fetch stage.
// master: the fetch stage; slave: RAM plus downstream consumer.
interface tri_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic                  mem_en_out;
    logic [95:0]           mem_data_in;
    logic [383:0]          tri_out;
    logic                  tri_valid_out;
    logic                  tri_ready_in;

    modport master (
        output mem_addr_out,
        output mem_en_out,
        input  mem_data_in,
        output tri_out,
        output tri_valid_out,
        input  tri_ready_in
    );

    modport slave (
        input  mem_addr_out,
        input  mem_en_out,
        output mem_data_in,
        input  tri_out,
        input  tri_valid_out,
        output tri_ready_in
    );
endinterface

// File: rtl/tri_fetch.sv
// Triangle fetch: walks a contiguous triangle list in vertex RAM (three 96-bit
// words per triangle), appends w = W_ONE to each vertex and offers the assembled
// triangle downstream over valid/ready. Pulses done_out after the last one.
module tri_fetch #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned RAM_LATENCY = 2,
    parameter logic [31:0] W_ONE       = 32'h0001_0000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [15:0]           num_tris_in,
    tri_fetch_if.master           bus,
    output logic                  busy_out,
    output logic                  done_out
);
    localparam int unsigned L = RAM_LATENCY;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [15:0]           num_q;
    logic [15:0]           tri_cnt_q;
    logic [1:0]            iss_cnt_q;
    logic [L-1:0]          tag_vld_q;
    logic [L-1:0][1:0]     tag_q;
    logic [383:0]          tri_q;

    logic issue;
    logic handshake;
    logic last_tri;
    logic v2_arrives;

    assign issue      = (state_q == S_ISSUE);
    assign handshake  = (state_q == S_HOLD) && bus.tri_ready_in;
    assign last_tri   = ((tri_cnt_q + 16'd1) == num_q);
    assign v2_arrives = tag_vld_q[L-1] && (tag_q[L-1] == 2'd2);

    assign bus.mem_en_out    = issue;
    assign bus.mem_addr_out  = ptr_q;
    assign bus.tri_out       = tri_q;
    assign bus.tri_valid_out = (state_q == S_HOLD);
    assign busy_out          = (state_q != S_IDLE);
    assign done_out          = (state_q == S_FINISH);

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the list walk
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = (num_tris_in == 16'd0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iss_cnt_q == 2'd2) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (v2_arrives) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.tri_ready_in) begin
                    state_d = last_tri ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address pointer, list counters and latched list parameters
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ptr_q     <= '0;
            num_q     <= '0;
            tri_cnt_q <= '0;
            iss_cnt_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_in) begin
                ptr_q     <= base_addr_in;
                num_q     <= num_tris_in;
                tri_cnt_q <= '0;
            end
            if (issue) begin
                ptr_q     <= ptr_q + 1'b1;
                iss_cnt_q <= (iss_cnt_q == 2'd2) ? 2'd0 : iss_cnt_q + 2'd1;
            end
            if (handshake) begin
                tri_cnt_q <= tri_cnt_q + 16'd1;
            end
        end
    end

    // Tag pipe: follows each read through the RAM so the returning word lands in its slot
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tag_vld_q <= '0;
            tag_q     <= '0;
        end else begin
            tag_vld_q[0] <= issue;
            tag_q[0]     <= iss_cnt_q;
            for (int unsigned i = 1; i < L; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_q[i]     <= tag_q[i-1];
            end
        end
    end

    // Vertex capture with w inserted; nothing returns while HOLD, so tri_q is stable there
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tri_q <= '0;
        end else if (tag_vld_q[L-1]) begin
            case (tag_q[L-1])
                2'd0:    tri_q[127:0]   <= {W_ONE, bus.mem_data_in};
                2'd1:    tri_q[255:128] <= {W_ONE, bus.mem_data_in};
                2'd2:    tri_q[383:256] <= {W_ONE, bus.mem_data_in};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_fetch.sv
// Scoreboard bench for tri_fetch: stimulus pushes expected read addresses and
// triangles; a negedge monitor pops and compares whenever the DUT reads or transfers.
module tb_tri_fetch;
    localparam int unsigned AW = 16;
    localparam int unsigned L  = 2;
    localparam logic [31:0] W1 = 32'h0001_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0;
    logic [15:0] base_addr_in = '0;
    logic [15:0] num_tris_in = '0;
    logic        busy_out;
    logic        done_out;

    tri_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    tri_fetch #(.ADDR_WIDTH(AW), .RAM_LATENCY(L), .W_ONE(W1)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .base_addr_in (base_addr_in),
        .num_tris_in  (num_tris_in),
        .bus          (bus.master),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ready_mode = 1;   // 0 low, 1 high, 2 random

    logic [95:0]  ram [0:65535];
    logic [15:0]  rd_pipe [0:L-1];
    logic [15:0]  exp_addr [$];
    logic [383:0] exp_tri [$];
    int           xfer_cyc [$];
    logic         stall_prev = 1'b0;
    logic [383:0] held = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Vertex RAM: data for an address appears L cycles after it was presented
    always @(posedge clk_in) begin
        rd_pipe[0] <= bus.mem_addr_out;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_data_in = ram[rd_pipe[L-1]];

    // Downstream ready driver
    always @(posedge clk_in) begin
        #2;
        case (ready_mode)
            0:       bus.tri_ready_in = 1'b0;
            1:       bus.tri_ready_in = 1'b1;
            default: bus.tri_ready_in = ($urandom_range(0, 1) == 1);
        endcase
    end

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [383:0] ref_tri(input logic [15:0] base, input int t);
        logic [383:0] r;
        logic [15:0]  a;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            a = 16'(base + 16'(3 * t + k));
            r[128*k +: 128] = {W1, ram[a]};
        end
        return r;
    endfunction

    // Monitor: reads, transfers, stall stability, done pulses
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (bus.mem_en_out) begin
                chk("read_expected", 384'(exp_addr.size() != 0), 384'(1));
                if (exp_addr.size() != 0) chk("read_addr", 384'(bus.mem_addr_out), 384'(exp_addr.pop_front()));
            end
            if (stall_prev) begin
                chk("stall_valid", 384'(bus.tri_valid_out), 384'(1));
                chk("stall_data", bus.tri_out, held);
                chk("stall_no_read", 384'(bus.mem_en_out), 384'(0));
            end
            if (bus.tri_valid_out) begin
                if (bus.tri_ready_in) begin
                    chk("tri_expected", 384'(exp_tri.size() != 0), 384'(1));
                    if (exp_tri.size() != 0) chk("tri_data", bus.tri_out, exp_tri.pop_front());
                    xfer_cyc.push_back(cyc);
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    held = bus.tri_out;
                end
            end else begin
                stall_prev = 1'b0;
            end
            if (done_out) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Push expectations, pulse start; returns 1 time unit into cycle 1
    task automatic launch(input logic [15:0] base, input int num);
        for (int i = 0; i < 3 * num; i++) exp_addr.push_back(16'(base + 16'(i)));
        for (int t = 0; t < num; t++) exp_tri.push_back(ref_tri(base, t));
        base_addr_in = base;
        num_tris_in  = 16'(num);
        start_in     = 1'b1;
        tick();
        start_in     = 1'b0;
        base_addr_in = $urandom;
        num_tris_in  = $urandom;
    endtask

    task automatic wait_idle(input int d0, input int limit);
        int n;
        n = 0;
        @(negedge clk_in);
        while (busy_out && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        chk("list_timeout_busy", 384'(busy_out), 384'(0));
        chk("done_count", 384'(done_cnt), 384'(d0 + 1));
        chk("tri_queue_empty", 384'(exp_tri.size()), 384'(0));
        chk("addr_queue_empty", 384'(exp_addr.size()), 384'(0));
        tick();
    endtask

    task automatic run_list(input logic [15:0] base, input int num);
        int d0;
        d0 = done_cnt;
        launch(base, num);
        wait_idle(d0, 100 + num * 80);
    endtask

    initial begin
        int d0;
        int n;
        for (int i = 0; i < 65536; i++) ram[i] = {$urandom, $urandom, $urandom};
        bus.tri_ready_in = 1'b1;

        // Reset state
        rst_in = 1'b0;
        repeat (3) tick();
        @(negedge clk_in);
        chk("rst_en", 384'(bus.mem_en_out), 384'(0));
        chk("rst_addr", 384'(bus.mem_addr_out), 384'(0));
        chk("rst_tri", bus.tri_out, 384'(0));
        chk("rst_valid", 384'(bus.tri_valid_out), 384'(0));
        chk("rst_busy", 384'(busy_out), 384'(0));
        chk("rst_done", 384'(done_out), 384'(0));
        tick();
        rst_in = 1'b1;
        tick();

        // Single triangle, exact timing
        ram[16'h0010] = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101};
        ram[16'h0011] = {32'h0000_0203, 32'h0000_0202, 32'h0000_0201};
        ram[16'h0012] = {32'h0000_0303, 32'h0000_0302, 32'h0000_0301};
        ready_mode = 1;
        d0 = done_cnt;
        launch(16'h0010, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            chk($sformatf("t1_en_c%0d", c), 384'(bus.mem_en_out), 384'(c <= 3));
            if (c <= 3) chk($sformatf("t1_addr_c%0d", c), 384'(bus.mem_addr_out), 384'(16'h0010 + c - 1));
            chk($sformatf("t1_valid_c%0d", c), 384'(bus.tri_valid_out), 384'(c == 6));
            chk($sformatf("t1_done_c%0d", c), 384'(done_out), 384'(c == 7));
            chk($sformatf("t1_busy_c%0d", c), 384'(busy_out), 384'(c <= 7));
            if (c == 6) begin
                chk("t1_w0", 384'(bus.tri_out[127:96]), 384'(W1));
                chk("t1_w1", 384'(bus.tri_out[255:224]), 384'(W1));
                chk("t1_w2", 384'(bus.tri_out[383:352]), 384'(W1));
            end
            tick();
        end
        chk("t1_done_count", 384'(done_cnt), 384'(d0 + 1));

        // Four triangles back to back
        xfer_cyc.delete();
        run_list(16'h0100, 4);
        chk("t2_xfer_count", 384'(xfer_cyc.size()), 384'(4));
        for (int i = 1; i < 4 && i < xfer_cyc.size(); i++)
            chk($sformatf("t2_spacing_%0d", i), 384'(xfer_cyc[i] - xfer_cyc[i-1]), 384'(6));

        // Downstream stall of 10 cycles, start_in while busy ignored
        ready_mode = 0;
        d0 = done_cnt;
        launch(16'h0200, 2);
        n = 0;
        @(negedge clk_in);
        while (!bus.tri_valid_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("t3_valid_seen", 384'(bus.tri_valid_out), 384'(1));
        for (int s = 0; s < 10; s++) begin
            tick();
            if (s == 4) begin
                base_addr_in = 16'h1234;
                num_tris_in  = 16'd7;
                start_in     = 1'b1;
            end else begin
                start_in = 1'b0;
            end
            @(negedge clk_in);
        end
        start_in = 1'b0;
        ready_mode = 1;
        wait_idle(d0, 200);

        // Empty list
        d0 = done_cnt;
        launch(16'h0300, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            chk($sformatf("t4_done_c%0d", c), 384'(done_out), 384'(c == 1));
            chk($sformatf("t4_busy_c%0d", c), 384'(busy_out), 384'(c == 1));
            chk($sformatf("t4_en_c%0d", c), 384'(bus.mem_en_out), 384'(0));
            chk($sformatf("t4_valid_c%0d", c), 384'(bus.tri_valid_out), 384'(0));
            tick();
        end
        chk("t4_done_count", 384'(done_cnt), 384'(d0 + 1));

        // Address wrap at top of space
        run_list(16'hFFFE, 1);

        // Reset during second triangle's WAIT
        ready_mode = 1;
        d0 = done_cnt;
        launch(16'h0400, 3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (c < 10) tick();
        end
        rst_in = 1'b0;
        exp_addr.delete();
        exp_tri.delete();
        tick();
        @(negedge clk_in);
        chk("t6_en", 384'(bus.mem_en_out), 384'(0));
        chk("t6_addr", 384'(bus.mem_addr_out), 384'(0));
        chk("t6_tri", bus.tri_out, 384'(0));
        chk("t6_valid", 384'(bus.tri_valid_out), 384'(0));
        chk("t6_busy", 384'(busy_out), 384'(0));
        chk("t6_done", 384'(done_out), 384'(0));
        tick();
        rst_in = 1'b1;
        repeat (4) tick();
        chk("t6_no_done", 384'(done_cnt), 384'(d0));
        run_list(16'h0500, 2);

        // Randomized lists with random backpressure
        ready_mode = 2;
        for (int r = 0; r < 10; r++) begin
            logic [15:0] b;
            b = (r % 3 == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            run_list(b, $urandom_range(0, 5));
        end
        ready_mode = 1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
